ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of the decode stage's ID/EX latch. It consumes the ID/EX control groups, operands, sign-extended immediate, NPC and destination fields. It computes the ALU result, zero flag, branch target and destination register, and registers them with the forwarded WB/M controls into the EX/MEM latch feeding the memory stage. An optional iterative multiplier stalls upstream while it runs.

## Interface
- No parameters; all widths are fixed by the 32-bit MIPS datapath.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_ex_wb  in  2  {regwrite, memtoreg}
- id_ex_m  in  3  {branch, memread, memwrite}
- id_ex_ex  in  4  {regdst, aluop[1:0], alusrc}
- id_ex_npc  in  32  PC+4 of the instruction
- id_ex_reg1  in  32  rs operand
- id_ex_reg2  in  32  rt operand
- id_ex_sign_ext  in  32  sign-extended immediate; [5:0] is funct
- id_ex_instr20_16  in  5  rt field
- id_ex_instr15_11  in  5  rd field
- ex_busy  out  1  combinational; upstream must hold ID/EX contents while high
- ex_mem_wb  out  2  registered WB controls
- ex_mem_m  out  3  registered M controls
- ex_mem_btgt  out  32  registered branch target
- ex_mem_zero  out  1  registered zero flag
- ex_mem_alu_result  out  32  registered ALU or multiplier result
- ex_mem_rdata2  out  32  registered id_ex_reg2, used as store data
- ex_mem_dest  out  5  registered destination register

## Operation
- Operand B is id_ex_sign_ext when alusrc=1, otherwise id_ex_reg2.
- dest is id_ex_instr15_11 when regdst=1, otherwise id_ex_instr20_16.
- btgt = id_ex_npc + (id_ex_sign_ext << 2), modulo 2^32.
- ALU function by aluop:
  - 00: add.
  - 01: sub.
  - 11: add.
  - 10: decode funct. 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - slt is a signed compare; the result is 32'd1 or 32'd0.
  - Any other funct gives a result of 0.
- Add and sub wrap with no overflow trap.
- zero = (ALU result == 0).
- The EX/MEM latch loads every rising edge unless ex_busy is high.
- While ex_busy is high, the latch loads a bubble: wb=0, m=0, all data fields 0.

## Timing
- Reset (rst=0, asynchronous): all ex_mem_* outputs are 0, the multiplier FSM is IDLE and the counter is 0.
- Non-multiply instructions: 1-cycle latency, ID/EX inputs to ex_mem_* at the next edge. ex_busy stays 0.
- Multiplier FSM (only with EX_MUL_EN). A multiply is aluop=10 with funct 011000.
  - IDLE with a multiply present: ex_busy=1. At the edge, capture A and B, clear the accumulator, set cnt=0, go to MUL.
  - MUL: ex_busy=1. Each edge does one shift-add step and increments cnt. The 32nd step (cnt=31) goes to DONE.
  - DONE: ex_busy=0. At the edge the latch captures the low 32 bits of the product with the instruction's controls and dest, then the FSM returns to IDLE.
  - Total: ex_busy is high for exactly 33 cycles, and the result appears at the 34th edge after presentation.
- Upstream advances at the DONE edge, so a multiply immediately following another restarts from IDLE.
- Reset asserted mid-multiply aborts it. Outputs clear immediately; nothing is written.
- ID/EX inputs changing while ex_busy=1 violate the protocol; behaviour is unspecified.

## Configuration
- EX_MUL_EN defined: the iterative multiplier and FSM are compiled in, and funct 011000 performs a 32x32 multiply with low-32 result.
- EX_MUL_EN undefined: no FSM, ex_busy is tied to 0, and funct 011000 falls into "other funct" (result 0, zero=1, single-cycle).

## Test plan
- R-type add, aluop=10, funct 100000, reg1=5, reg2=7, regdst=1, rd=3 -> next edge: alu_result=12, zero=0, dest=3, wb and m passed through.
- lw: aluop=00, alusrc=1, reg1=0x100, sign_ext=0xFFFFFFFC, npc=0x40 -> alu_result=0xFC, dest=rt, btgt=0x30.
- beq: aluop=01, reg1=reg2=9 -> zero=1, alu_result=0. Then slt with reg1=-1, reg2=1 -> alu_result=1.
- Reset pulse (rst=0 for 1 cycle, asynchronous to clk) with nonzero latch contents -> all ex_mem_* outputs 0 immediately, without waiting for an edge.
- EX_MUL_EN: mult with reg1=7, reg2=0xFFFFFFFD -> ex_busy high for 33 cycles, bubbles in EX/MEM meanwhile, then alu_result=0xFFFFFFEB.
- EX_MUL_EN: rst=0 at cycle 10 of a multiply -> outputs 0, FSM IDLE. A subsequent add with no multiply present completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch target and destination select feeding the EX/MEM latch.
// Define EX_MUL_EN to compile in the iterative shift-add multiplier (funct 011000).
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  id_ex_wb,
    input  logic [2:0]  id_ex_m,
    input  logic [3:0]  id_ex_ex,
    input  logic [31:0] id_ex_npc,
    input  logic [31:0] id_ex_reg1,
    input  logic [31:0] id_ex_reg2,
    input  logic [31:0] id_ex_sign_ext,
    input  logic [4:0]  id_ex_instr20_16,
    input  logic [4:0]  id_ex_instr15_11,
    output logic        ex_busy,
    output logic [1:0]  ex_mem_wb,
    output logic [2:0]  ex_mem_m,
    output logic [31:0] ex_mem_btgt,
    output logic        ex_mem_zero,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_rdata2,
    output logic [4:0]  ex_mem_dest
);

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    logic        regdst;
    logic [1:0]  aluop;
    logic        alusrc;
    logic [5:0]  funct;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [31:0] result;
    logic        busy;

    assign regdst = id_ex_ex[3];
    assign aluop  = id_ex_ex[2:1];
    assign alusrc = id_ex_ex[0];
    assign funct  = id_ex_sign_ext[5:0];
    assign op_b   = alusrc ? id_ex_sign_ext : id_ex_reg2;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_result = '0;
        case (aluop)
            2'b01: alu_result = id_ex_reg1 - op_b;
            2'b10: begin
                case (funct)
                    F_ADD:   alu_result = id_ex_reg1 + op_b;
                    F_SUB:   alu_result = id_ex_reg1 - op_b;
                    F_AND:   alu_result = id_ex_reg1 & op_b;
                    F_OR:    alu_result = id_ex_reg1 | op_b;
                    F_SLT:   alu_result = ($signed(id_ex_reg1) < $signed(op_b)) ? 32'd1 : 32'd0;
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = id_ex_reg1 + op_b;
        endcase
    end

`ifdef EX_MUL_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q,    acc_d;
    logic        is_mul;

    assign is_mul = (aluop == 2'b10) && (funct == 6'b011000);

    // Only the low 32 product bits are kept, so the accumulator never needs to be wider.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (is_mul) begin
                    mcand_d  = id_ex_reg1;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy   = ((state_q == ST_IDLE) && is_mul) || (state_q == ST_MUL);
    assign result = (state_q == ST_DONE) ? acc_q : alu_result;
`else
    assign busy   = 1'b0;
    assign result = alu_result;
`endif

    assign ex_busy = busy;

    logic [1:0]  wb_q,    wb_d;
    logic [2:0]  m_q,     m_d;
    logic [31:0] btgt_q,  btgt_d;
    logic        zero_q,  zero_d;
    logic [31:0] res_q,   res_d;
    logic [31:0] rdata2_q, rdata2_d;
    logic [4:0]  dest_q,  dest_d;

    // While the multiplier runs the latch takes a bubble so nothing downstream commits.
    always_comb begin
        wb_d     = id_ex_wb;
        m_d      = id_ex_m;
        btgt_d   = id_ex_npc + (id_ex_sign_ext << 2);
        zero_d   = (result == 32'd0);
        res_d    = result;
        rdata2_d = id_ex_reg2;
        dest_d   = regdst ? id_ex_instr15_11 : id_ex_instr20_16;
        if (busy) begin
            wb_d     = '0;
            m_d      = '0;
            btgt_d   = '0;
            zero_d   = 1'b0;
            res_d    = '0;
            rdata2_d = '0;
            dest_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q     <= '0;
            m_q      <= '0;
            btgt_q   <= '0;
            zero_q   <= 1'b0;
            res_q    <= '0;
            rdata2_q <= '0;
            dest_q   <= '0;
        end else begin
            wb_q     <= wb_d;
            m_q      <= m_d;
            btgt_q   <= btgt_d;
            zero_q   <= zero_d;
            res_q    <= res_d;
            rdata2_q <= rdata2_d;
            dest_q   <= dest_d;
        end
    end

    assign ex_mem_wb         = wb_q;
    assign ex_mem_m          = m_q;
    assign ex_mem_btgt       = btgt_q;
    assign ex_mem_zero       = zero_q;
    assign ex_mem_alu_result = res_q;
    assign ex_mem_rdata2     = rdata2_q;
    assign ex_mem_dest       = dest_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes expected EX/MEM contents, monitor pops per edge.
// Handles both builds (EX_MUL_EN defined or not).
module tb_ex_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] btgt;
        logic        zero;
        logic [31:0] res;
        logic [31:0] rdata2;
        logic [4:0]  dest;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  id_ex_wb = '0;
    logic [2:0]  id_ex_m = '0;
    logic [3:0]  id_ex_ex = '0;
    logic [31:0] id_ex_npc = '0;
    logic [31:0] id_ex_reg1 = '0;
    logic [31:0] id_ex_reg2 = '0;
    logic [31:0] id_ex_sign_ext = '0;
    logic [4:0]  id_ex_instr20_16 = '0;
    logic [4:0]  id_ex_instr15_11 = '0;
    logic        ex_busy;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_m;
    logic [31:0] ex_mem_btgt;
    logic        ex_mem_zero;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_rdata2;
    logic [4:0]  ex_mem_dest;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];
    exp_t mon_e;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
        .id_ex_npc(id_ex_npc), .id_ex_reg1(id_ex_reg1), .id_ex_reg2(id_ex_reg2),
        .id_ex_sign_ext(id_ex_sign_ext),
        .id_ex_instr20_16(id_ex_instr20_16), .id_ex_instr15_11(id_ex_instr15_11),
        .ex_busy(ex_busy),
        .ex_mem_wb(ex_mem_wb), .ex_mem_m(ex_mem_m), .ex_mem_btgt(ex_mem_btgt),
        .ex_mem_zero(ex_mem_zero), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_rdata2(ex_mem_rdata2), .ex_mem_dest(ex_mem_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".wb"},     32'(ex_mem_wb),         32'(e.wb));
        check({tag, ".m"},      32'(ex_mem_m),          32'(e.m));
        check({tag, ".btgt"},   ex_mem_btgt,            e.btgt);
        check({tag, ".zero"},   32'(ex_mem_zero),       32'(e.zero));
        check({tag, ".result"}, ex_mem_alu_result,      e.res);
        check({tag, ".rdata2"}, ex_mem_rdata2,          e.rdata2);
        check({tag, ".dest"},   32'(ex_mem_dest),       32'(e.dest));
    endtask

    function automatic logic is_mul(input instr_t t);
`ifdef EX_MUL_EN
        return (t.ex[2:1] == 2'b10) && (t.sext[5:0] == 6'b011000);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: straight from the instruction semantics.
    function automatic exp_t model(input instr_t t);
        exp_t e;
        logic [31:0] a, b;
        longint unsigned prod;
        a = t.reg1;
        b = t.ex[0] ? t.sext : t.reg2;
        prod = 64'(a) * 64'(b);
        if (t.ex[2:1] == 2'b01)      e.res = a - b;
        else if (t.ex[2:1] != 2'b10) e.res = a + b;
        else if (t.sext[5:0] == 6'h20) e.res = a + b;
        else if (t.sext[5:0] == 6'h22) e.res = a - b;
        else if (t.sext[5:0] == 6'h24) e.res = a & b;
        else if (t.sext[5:0] == 6'h25) e.res = a | b;
        else if (t.sext[5:0] == 6'h2a) e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (is_mul(t))            e.res = prod[31:0];
        else                           e.res = 32'd0;
        e.zero   = (e.res == 32'd0);
        e.wb     = t.wb;
        e.m      = t.m;
        e.btgt   = t.npc + t.sext * 32'd4;
        e.rdata2 = t.reg2;
        e.dest   = t.ex[3] ? t.rd : t.rt;
        return e;
    endfunction

    task automatic drive(input instr_t t);
        id_ex_wb         = t.wb;
        id_ex_m          = t.m;
        id_ex_ex         = t.ex;
        id_ex_npc        = t.npc;
        id_ex_reg1       = t.reg1;
        id_ex_reg2       = t.reg2;
        id_ex_sign_ext   = t.sext;
        id_ex_instr20_16 = t.rt;
        id_ex_instr15_11 = t.rd;
    endtask

    // Called at posedge+2; returns at posedge+2 after the instruction's result edge.
    task automatic issue(input instr_t t);
        exp_t e;
        e = model(t);
        drive(t);
        if (is_mul(t)) begin
            for (int k = 0; k < 33; k++) begin
                sb.push_back('0);
                #1 check("busy_high", 32'(ex_busy), 32'd1);
                @(posedge clk);
                #2;
            end
        end
        sb.push_back(e);
        #1 check("busy_low", 32'(ex_busy), 32'd0);
        @(posedge clk);
        #2;
    endtask

    function automatic instr_t rand_instr();
        instr_t t;
        logic [31:0] r, s;
        logic [5:0] f;
        r = $urandom;
        s = $urandom;
        t.wb = r[1:0];
        t.m  = r[4:2];
        t.ex = r[8:5];
        t.rt = r[13:9];
        t.rd = r[18:14];
        case (r[22:20])
            3'd0: f = 6'h20;
            3'd1: f = 6'h22;
            3'd2: f = 6'h24;
            3'd3: f = 6'h25;
            3'd4: f = 6'h2a;
            3'd5: f = 6'h18;
            default: f = s[5:0];
        endcase
        t.sext = {s[31:6], f};
        t.npc  = $urandom;
        t.reg1 = $urandom;
        t.reg2 = (r[25:24] == 2'b00) ? t.reg1 : $urandom;
        return t;
    endfunction

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_outputs("exmem", mon_e);
        end
    end

    initial begin
        instr_t t;
        exp_t e;

        // Reset state.
        #2 check_outputs("reset", '0);
        check("reset.busy", 32'(ex_busy), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #2;

        // R-type add, regdst=1.
        t = '{wb: 2'b10, m: 3'b000, ex: 4'b1100, npc: 32'h0000_0010, reg1: 32'd5, reg2: 32'd7,
              sext: 32'h0000_0020, rt: 5'd9, rd: 5'd3};
        e = model(t);
        check("model.add", e.res, 32'd12);
        issue(t);

        // lw: address add with immediate, dest=rt.
        t = '{wb: 2'b11, m: 3'b010, ex: 4'b0001, npc: 32'h0000_0040, reg1: 32'h100, reg2: 32'h55,
              sext: 32'hFFFF_FFFC, rt: 5'd8, rd: 5'd31};
        e = model(t);
        check("model.lw_btgt", e.btgt, 32'h0000_0030);
        issue(t);

        // beq with equal operands, then slt -1 < 1.
        t = '{wb: 2'b00, m: 3'b100, ex: 4'b0010, npc: 32'h0000_0100, reg1: 32'd9, reg2: 32'd9,
              sext: 32'h0000_0004, rt: 5'd1, rd: 5'd2};
        issue(t);
        t = '{wb: 2'b10, m: 3'b000, ex: 4'b1100, npc: 32'h0000_0104, reg1: 32'hFFFF_FFFF, reg2: 32'd1,
              sext: 32'h0000_002A, rt: 5'd4, rd: 5'd5};
        issue(t);

        // Multiply funct (stall and product with EX_MUL_EN, plain "other funct" without).
        t = '{wb: 2'b10, m: 3'b000, ex: 4'b1100, npc: 32'h0000_0200, reg1: 32'd7, reg2: 32'hFFFF_FFFD,
              sext: 32'h0000_0018, rt: 5'd6, rd: 5'd7};
        issue(t);

        // Asynchronous reset pulse between edges with a nonzero latch.
        t = '{wb: 2'b11, m: 3'b111, ex: 4'b1100, npc: 32'h0000_0300, reg1: 32'd1, reg2: 32'd2,
              sext: 32'h0000_0025, rt: 5'd10, rd: 5'd11};
        issue(t);
        #1 rst = 1'b0;
        #1 check_outputs("async_rst", '0);
        #2 rst = 1'b1;
        @(posedge clk);
        #2;

`ifdef EX_MUL_EN
        // Abort a multiply with reset after ten busy cycles.
        t = '{wb: 2'b10, m: 3'b000, ex: 4'b1100, npc: 32'h0000_0400, reg1: 32'd123, reg2: 32'd456,
              sext: 32'h0000_0018, rt: 5'd12, rd: 5'd13};
        drive(t);
        for (int k = 0; k < 10; k++) begin
            sb.push_back('0);
            #1 check("abort.busy_high", 32'(ex_busy), 32'd1);
            @(posedge clk);
            #2;
        end
        #1 rst = 1'b0;
        #1 check_outputs("abort_rst", '0);
        t = '{wb: 2'b10, m: 3'b001, ex: 4'b1100, npc: 32'h0000_0500, reg1: 32'd40, reg2: 32'd2,
              sext: 32'h0000_0020, rt: 5'd14, rd: 5'd15};
        drive(t);
        #1 check("abort.idle_busy", 32'(ex_busy), 32'd0);
        sb.push_back(model(t));
        #1 rst = 1'b1;
        @(posedge clk);
        #2;
`endif

        for (int i = 0; i < 300; i++) issue(rand_instr());

        @(posedge clk);
        #3 check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
